// File: rtl/pwm_capture.sv
// Multi-channel PWM input capture: measures period and high time of each pwmi
// input in clk cycles and exposes them on the generator-compatible register bus.
module pwm_capture #(
  parameter int unsigned CHANNELS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd,
  input  logic                wr,
  input  logic [7:0]          din,
  input  logic [6:0]          adrs,
  output logic [7:0]          dout,
  input  logic [CHANNELS-1:0] pwmi,
  output logic [CHANNELS-1:0] capv
);

  logic [CHANNELS-1:0] sync1, sync2, sync3;
  logic [CHANNELS-1:0] rise, fall;
  logic [CHANNELS-1:0] en, en_nxt, ovf, valid, armed, fall_seen, stuck;
  logic [CHANNELS-1:0] ovf_set, store;
  logic [CHANNELS-1:0] sel_ctrl, sel_per, sel_duty;
  logic [7:0]          cnt    [CHANNELS];
  logic [7:0]          hi     [CHANNELS];
  logic [7:0]          period [CHANNELS];
  logic [7:0]          duty   [CHANNELS];
  logic [7:0]          rdata;
  logic                unused_din;

  assign unused_din = ^{din[7:3], din[1]};

  // sync2 is the synchronized level; sync3 is the edge-detect history flop
  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= pwmi;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_comb begin
    sel_ctrl = '0;
    sel_per  = '0;
    sel_duty = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      sel_ctrl[n] = (adrs == 7'(n * 12));
      sel_per[n]  = (adrs == 7'(n * 12 + 4));
      sel_duty[n] = (adrs == 7'(n * 12 + 8));
    end
  end

  // Capture logic follows the post-write enable so a disable takes effect on the write edge
  always_comb begin
    en_nxt  = en;
    ovf_set = '0;
    store   = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      en_nxt[n]  = (wr && sel_ctrl[n]) ? din[0] : en[n];
      ovf_set[n] = en_nxt[n] && !rise[n] && (cnt[n] == 8'hFF) && !stuck[n];
      store[n]   = en_nxt[n] && rise[n] && armed[n];
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      if (sel_ctrl[n]) rdata = {4'b0000, sync2[n], ovf[n], valid[n], en[n]};
      if (sel_per[n])  rdata = period[n];
      if (sel_duty[n]) rdata = duty[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (rd) begin
      dout <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= '0;
      ovf       <= '0;
      valid     <= '0;
      armed     <= '0;
      fall_seen <= '0;
      stuck     <= '0;
      capv      <= '0;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        cnt[n]    <= '0;
        hi[n]     <= '0;
        period[n] <= '0;
        duty[n]   <= '0;
      end
    end else begin
      en   <= en_nxt;
      capv <= store;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        if (ovf_set[n]) begin
          ovf[n] <= 1'b1;
        end else if (wr && sel_ctrl[n] && din[2]) begin
          ovf[n] <= 1'b0;
        end

        if (!en_nxt[n]) begin
          cnt[n]       <= '0;
          armed[n]     <= 1'b0;
          valid[n]     <= 1'b0;
          fall_seen[n] <= 1'b0;
          stuck[n]     <= 1'b0;
        end else if (rise[n]) begin
          // cnt restarts at 1 so that its value at the next rise equals the period
          cnt[n]       <= 8'd1;
          armed[n]     <= 1'b1;
          fall_seen[n] <= 1'b0;
          stuck[n]     <= 1'b0;
          if (armed[n]) begin
            period[n] <= cnt[n];
            duty[n]   <= !fall_seen[n] ? 8'h00 :
                         (hi[n] >= cnt[n]) ? cnt[n] : hi[n];
            valid[n]  <= 1'b1;
          end
        end else begin
          if (cnt[n] != 8'hFF) cnt[n] <= cnt[n] + 8'd1;
          if (fall[n] && armed[n]) begin
            hi[n]        <= cnt[n];
            fall_seen[n] <= 1'b1;
          end
          // stuck marks that this saturation already raised ovf, so a clear is not undone
          if (cnt[n] == 8'hFF && !stuck[n]) begin
            stuck[n] <= 1'b1;
            valid[n] <= 1'b0;
            armed[n] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven register-map vectors plus
// PWM waveform sequences, with read expectations queued and checked on dout.
module tb_pwm_capture;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       rd   = 1'b0;
  logic       wr   = 1'b0;
  logic [7:0] din  = '0;
  logic [6:0] adrs = '0;
  logic [7:0] dout;
  logic [7:0] pwmi = '0;
  logic [7:0] capv;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];

  int unsigned hlen[8];
  int unsigned llen[8];
  int unsigned phase[8];
  int unsigned capv_cnt[8];
  logic [7:0]  gen_on = '0;
  logic [7:0]  lvl    = '0;
  int unsigned base;

  typedef struct {
    logic       r;
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;
  vec_t vecs[18];

  always #5 clk = ~clk;

  pwm_capture #(.CHANNELS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .rd   (rd),
    .wr   (wr),
    .din  (din),
    .adrs (adrs),
    .dout (dout),
    .pwmi (pwmi),
    .capv (capv)
  );

  // Pin waveforms are updated on the falling edge; phase p drives high while p < hlen
  always @(negedge clk) begin
    for (int n = 0; n < 8; n++) begin
      if (gen_on[n]) begin
        pwmi[n]  = (phase[n] < hlen[n]);
        phase[n] = (phase[n] + 1) % (hlen[n] + llen[n]);
      end else begin
        pwmi[n] = lvl[n];
      end
      if (capv[n]) capv_cnt[n]++;
    end
  end

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h", nm, got, exp);
    end
  endtask

  task automatic bus_op(input logic r, input logic w, input logic [6:0] a,
                        input logic [7:0] d, input logic [7:0] e, input string nm);
    logic [7:0] exp;
    rd = r; wr = w; adrs = a; din = d;
    if (r) exp_q.push_back(e);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    if (r) begin
      exp = exp_q.pop_front();
      check(nm, dout, exp);
    end
  endtask

  task automatic rd_chk(input logic [6:0] a, input logic [7:0] e, input string nm);
    bus_op(1'b1, 1'b0, a, 8'h00, e, nm);
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [7:0] d);
    bus_op(1'b0, 1'b1, a, d, 8'h00, "");
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int ch, input int unsigned p);
    bit hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(posedge clk); #1;
      if (phase[ch] == p) hit = 1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_phase ch%0d timeout waiting for phase %0d", ch, p);
    end
  endtask

  task automatic start_gen(input int ch, input int unsigned h, input int unsigned l);
    hlen[ch]   = h;
    llen[ch]   = l;
    phase[ch]  = 0;
    gen_on[ch] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 7'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 7'h04, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 7'h08, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 7'h04, 8'h55, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 7'h04, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 7'h08, 8'hAA, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 7'h08, 8'h00, 8'h00};
    vecs[7]  = '{1'b1, 1'b1, 7'h0C, 8'h01, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 7'h0C, 8'h00, 8'h01};
    vecs[9]  = '{1'b0, 1'b1, 7'h0C, 8'hFE, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 7'h0C, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 7'h60, 8'h00, 8'h00};
    vecs[12] = '{1'b1, 1'b0, 7'h7F, 8'h00, 8'h00};
    vecs[13] = '{1'b0, 1'b1, 7'h01, 8'hFF, 8'h00};
    vecs[14] = '{1'b1, 1'b0, 7'h00, 8'h00, 8'h00};
    vecs[15] = '{1'b1, 1'b0, 7'h0D, 8'h00, 8'h00};
    vecs[16] = '{1'b0, 1'b1, 7'h60, 8'h01, 8'h00};
    vecs[17] = '{1'b1, 1'b0, 7'h00, 8'h00, 8'h00};

    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    check("dout_reset", dout, 8'h00);
    check("capv_reset", capv, 8'h00);

    for (int i = 0; i < 18; i++)
      bus_op(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e, $sformatf("vec%0d", i));

    cycles(20);
    base = 0;
    for (int n = 0; n < 8; n++) base += capv_cnt[n];
    check("capv_idle", 8'(base), 8'h00);

    // ch0: 50 high / 150 low
    wr_reg(7'h00, 8'h01);
    start_gen(0, 50, 150);
    cycles(500);
    wait_phase(0, 100);
    rd_chk(7'h04, 8'd200, "ch0_period");
    rd_chk(7'h08, 8'd50,  "ch0_duty");
    rd_chk(7'h00, 8'h03,  "ch0_ctrl_low");
    wait_phase(0, 20);
    rd_chk(7'h00, 8'h0B,  "ch0_ctrl_high");
    wait_phase(0, 100);
    base = capv_cnt[0];
    cycles(1000);
    check("ch0_capv_pulses", 8'(capv_cnt[0] - base), 8'd5);

    // ch3: stuck low -> overflow, clear, then recover
    wr_reg(7'h24, 8'h01);
    cycles(300);
    rd_chk(7'h24, 8'h05, "ch3_ovf");
    wr_reg(7'h24, 8'h05);
    rd_chk(7'h24, 8'h01, "ch3_ovf_cleared");
    start_gen(3, 30, 70);
    cycles(350);
    wait_phase(3, 80);
    rd_chk(7'h24, 8'h03, "ch3_ctrl_valid");
    rd_chk(7'h28, 8'd100, "ch3_period");
    rd_chk(7'h2C, 8'd30,  "ch3_duty");

    // ch0: 0% duty -> overflow with held values, then 1-cycle pulse every 10
    wait_phase(0, 100);
    gen_on[0] = 1'b0;
    lvl[0]    = 1'b0;
    cycles(300);
    rd_chk(7'h00, 8'h05,  "ch0_zero_duty_ctrl");
    rd_chk(7'h04, 8'd200, "ch0_zero_duty_period_hold");
    rd_chk(7'h08, 8'd50,  "ch0_zero_duty_duty_hold");
    start_gen(0, 1, 9);
    cycles(100);
    rd_chk(7'h04, 8'd10, "ch0_pulse_period");
    rd_chk(7'h08, 8'd1,  "ch0_pulse_duty");

    // reset in the middle of a measurement
    gen_on[3] = 1'b0;
    lvl[3]    = 1'b0;
    start_gen(0, 50, 150);
    cycles(500);
    wait_phase(0, 100);
    rd_chk(7'h04, 8'd200, "pre_rst_period");
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    check("dout_after_rst", dout, 8'h00);
    rd_chk(7'h00, 8'h00, "rst_ctrl0");
    rd_chk(7'h04, 8'h00, "rst_period0");
    rd_chk(7'h08, 8'h00, "rst_duty0");
    rd_chk(7'h24, 8'h00, "rst_ctrl3");
    rd_chk(7'h28, 8'h00, "rst_period3");
    wr_reg(7'h00, 8'h01);
    base = capv_cnt[0];
    wait_phase(0, 100);
    rd_chk(7'h00, 8'h01, "reen_one_rise_ctrl");
    check("reen_one_rise_capv", 8'(capv_cnt[0] - base), 8'd0);
    wait_phase(0, 100);
    rd_chk(7'h00, 8'h03, "reen_two_rise_ctrl");
    rd_chk(7'h04, 8'd200, "reen_period");
    rd_chk(7'h08, 8'd50,  "reen_duty");
    check("reen_two_rise_capv", 8'(capv_cnt[0] - base), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
